sar_scan_controller: RTL

- Next-generation SAR conversion controller for the ideal SAR ADC benchmark.
- Sequences track/sample, N_BITS binary-search trials and result hand-off over up to N_CHANNELS multiplexed analog inputs.
- Drives the mux select, sample switch and trial DAC code, and takes the comparator decision.
- Returns results tagged by channel over a valid/ready interface; supports single-scan and continuous modes.

---
 rtl/sar_scan_pkg.sv | 16 +
 rtl/sar_channel_picker.sv | 33 +++
 rtl/sar_scan_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sar_scan_pkg.sv
// Shared types and helpers for the SAR scan controller and its channel picker.
package sar_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        RESULT  = 2'd3
    } state_e;

    // Index width for a value range, never narrower than one bit.
    function automatic int clog2Min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/sar_channel_picker.sv
// Combinational channel picker: finds the next enabled channel above the
// current one, flags when none remains (wrap), and reports the lowest
// enabled channel of the mask.
module sar_channel_picker
    import sar_scan_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int CH_W       = 2
) (
    input  logic [N_CHANNELS-1:0] mask_i,
    input  logic [CH_W-1:0]       current_i,
    output logic [CH_W-1:0]       next_o,
    output logic                  wrap_o,
    output logic [CH_W-1:0]       lowest_o
);

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        next_o   = '0;
        wrap_o   = 1'b1;
        lowest_o = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_o = CH_W'(i);
                if (CH_W'(i) > current_i) begin
                    next_o = CH_W'(i);
                    wrap_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sar_scan_controller.sv
// SAR conversion controller: scans the enabled channels of a latched mask,
// running sample, MSB-first binary search and valid/ready result hand-off.
// Optional feature macro: SAR_OVERSAMPLE_EN (averages 2^OSR_LOG2 conversions
// per channel before presenting a result).
module sar_scan_controller
    import sar_scan_pkg::*;
#(
    parameter int N_BITS        = 10,
    parameter int N_CHANNELS    = 4,
    parameter int SAMPLE_CYCLES = 2
`ifdef SAR_OVERSAMPLE_EN
    ,
    parameter int OSR_LOG2      = 2
`endif
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                continuous,
    input  logic [N_CHANNELS-1:0]               channel_mask,
    input  logic                                feedback_value,
    output logic [clog2Min1(N_CHANNELS)-1:0]    channel_sel,
    output logic                                sample_en,
    output logic [N_BITS-1:0]                   dac_code,
    output logic                                busy,
    output logic [N_BITS-1:0]                   result_data,
    output logic [clog2Min1(N_CHANNELS)-1:0]    result_channel,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic                                scan_done
);

    localparam int CH_W = clog2Min1(N_CHANNELS);
    localparam int SC_W = clog2Min1(SAMPLE_CYCLES);
    localparam int TR_W = clog2Min1(N_BITS);
    localparam logic [SC_W-1:0]   SAMPLE_LAST = SC_W'(SAMPLE_CYCLES - 1);
    localparam logic [TR_W-1:0]   TRIAL_LAST  = TR_W'(N_BITS - 1);
    localparam logic [N_BITS-1:0] MSB_ONE     = {1'b1, {(N_BITS-1){1'b0}}};

    state_e                state_q;
    logic [N_CHANNELS-1:0] mask_q;
    logic                  cont_q;
    logic [N_BITS-1:0]     code_q;
    logic [TR_W-1:0]       trial_q;
    logic [SC_W-1:0]       sampleCnt_q;
    logic [CH_W-1:0]       channelSel_q;
    logic                  sampleEn_q;
    logic [N_BITS-1:0]     dacCode_q;
    logic [N_BITS-1:0]     resultData_q;
    logic                  resultValid_q;
    logic                  scanDone_q;

    logic [N_BITS-1:0]     bitUnderTest;
    logic [N_BITS-1:0]     committed_d;
    logic [N_CHANNELS-1:0] pickMask;
    logic [CH_W-1:0]       nextCh;
    logic                  wrap;
    logic [CH_W-1:0]       lowestCh;

`ifdef SAR_OVERSAMPLE_EN
    localparam int ACC_W = N_BITS + OSR_LOG2;
    localparam int REP_W = (OSR_LOG2 < 1) ? 1 : OSR_LOG2;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'((1 << OSR_LOG2) - 1);

    logic [ACC_W-1:0] acc_q;
    logic [REP_W-1:0] rep_q;
    logic [ACC_W-1:0] accSum_d;

    assign accSum_d = acc_q + ACC_W'(committed_d);
`endif

    // In IDLE the picker looks at the incoming mask so the first channel
    // is known on the accepting edge; afterwards it uses the latched copy.
    assign pickMask     = (state_q == IDLE) ? channel_mask : mask_q;
    assign bitUnderTest = MSB_ONE >> trial_q;
    assign committed_d  = code_q | (feedback_value ? bitUnderTest : '0);

    sar_channel_picker #(
        .N_CHANNELS (N_CHANNELS),
        .CH_W       (CH_W)
    ) u_picker (
        .mask_i    (pickMask),
        .current_i (channelSel_q),
        .next_o    (nextCh),
        .wrap_o    (wrap),
        .lowest_o  (lowestCh)
    );

    assign channel_sel    = channelSel_q;
    assign sample_en      = sampleEn_q;
    assign dac_code       = dacCode_q;
    assign busy           = (state_q != IDLE);
    assign result_data    = resultData_q;
    assign result_channel = channelSel_q;
    assign result_valid   = resultValid_q;
    assign scan_done      = scanDone_q;

    // Scan sequencer: state, latched scan setup, binary search and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            cont_q        <= 1'b0;
            code_q        <= '0;
            trial_q       <= '0;
            sampleCnt_q   <= '0;
            channelSel_q  <= '0;
            sampleEn_q    <= 1'b0;
            dacCode_q     <= '0;
            resultData_q  <= '0;
            resultValid_q <= 1'b0;
            scanDone_q    <= 1'b0;
`ifdef SAR_OVERSAMPLE_EN
            acc_q         <= '0;
            rep_q         <= '0;
`endif
        end else begin
            scanDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (|channel_mask)) begin
                        mask_q       <= channel_mask;
                        cont_q       <= continuous;
                        channelSel_q <= lowestCh;
                        state_q      <= SAMPLE;
                        sampleEn_q   <= 1'b1;
                        sampleCnt_q  <= '0;
`ifdef SAR_OVERSAMPLE_EN
                        acc_q        <= '0;
                        rep_q        <= '0;
`endif
                    end
                end
                SAMPLE: begin
                    if (sampleCnt_q == SAMPLE_LAST) begin
                        sampleEn_q <= 1'b0;
                        state_q    <= CONVERT;
                        code_q     <= '0;
                        trial_q    <= '0;
                        dacCode_q  <= MSB_ONE;
                    end else begin
                        sampleCnt_q <= sampleCnt_q + SC_W'(1);
                    end
                end
                CONVERT: begin
                    code_q <= committed_d;
                    if (trial_q == TRIAL_LAST) begin
                        dacCode_q <= '0;
`ifdef SAR_OVERSAMPLE_EN
                        if (rep_q != REP_LAST) begin
                            rep_q       <= rep_q + REP_W'(1);
                            acc_q       <= accSum_d;
                            state_q     <= SAMPLE;
                            sampleEn_q  <= 1'b1;
                            sampleCnt_q <= '0;
                        end else begin
                            acc_q         <= accSum_d;
                            resultData_q  <= accSum_d[ACC_W-1:OSR_LOG2];
                            resultValid_q <= 1'b1;
                            state_q       <= RESULT;
                        end
`else
                        resultData_q  <= committed_d;
                        resultValid_q <= 1'b1;
                        state_q       <= RESULT;
`endif
                    end else begin
                        trial_q   <= trial_q + TR_W'(1);
                        dacCode_q <= committed_d | (bitUnderTest >> 1);
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        resultValid_q <= 1'b0;
                        if (wrap) begin
                            scanDone_q <= 1'b1;
                        end
                        if (!wrap || cont_q) begin
                            channelSel_q <= wrap ? lowestCh : nextCh;
                            state_q      <= SAMPLE;
                            sampleEn_q   <= 1'b1;
                            sampleCnt_q  <= '0;
`ifdef SAR_OVERSAMPLE_EN
                            acc_q        <= '0;
                            rep_q        <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
